// File: rtl/bin_pkg.sv
// Shared types and constants for the binarization threshold controller.
package bin_pkg;

  typedef enum logic [1:0] {IDLE, DIV, CALC, HOLD} state_t;

  localparam logic [7:0] DEFAULT_TH = 8'd32;
  localparam logic [7:0] TH_OFFSET  = 8'd16;
  localparam logic [7:0] TH_MIN     = 8'd8;
  localparam logic [7:0] TH_MAX     = 8'd200;

  function automatic logic [7:0] clamp(input logic [9:0] v, input logic [7:0] lo,
                                       input logic [7:0] hi);
    if (v < {2'b00, lo})      return lo;
    else if (v > {2'b00, hi}) return hi;
    else                      return v[7:0];
  endfunction

endpackage

// File: rtl/serial_udiv.sv
// Restoring unsigned divider, one quotient bit per cycle, W cycles per divide.
module serial_udiv #(
  parameter int W = 29
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem, quo, dvs;
  logic [W-1:0]  rem_in, quo_in, dvs_in, rem_nx;
  logic [W:0]    shifted, trial;
  logic [CW-1:0] cnt;
  logic          qbit;

  // The start cycle already performs the first step, so operands go straight
  // into the datapath instead of being registered first.
  always_comb begin
    rem_in  = start ? '0 : rem;
    quo_in  = start ? dividend : quo;
    dvs_in  = start ? divisor : dvs;
    shifted = {rem_in, quo_in[W-1]};
    trial   = shifted - {1'b0, dvs_in};
    qbit    = ~trial[W];
    rem_nx  = qbit ? trial[W-1:0] : shifted[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      if (start || busy) begin
        rem <= rem_nx;
        quo <= {quo_in[W-2:0], qbit};
        dvs <= dvs_in;
        cnt <= start ? CW'(W - 1) : cnt - 1'b1;
      end
      done <= !start && (cnt == CW'(1));
    end
  end

  assign busy     = (cnt != '0);
  assign quotient = quo;

endmodule

// File: rtl/bin_thresh_ctrl.sv
// Per-frame mean-luminance threshold controller with manual override.
// Define BIN_TH_IIR_EN to smooth the computed threshold against the previous one.
module bin_thresh_ctrl
  import bin_pkg::*;
#(
  parameter int CNT_W = 21,
  parameter int SUM_W = 29
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       de,
  input  logic [7:0] luminance,
  input  logic       cfg_manual,
  input  logic [7:0] cfg_thresh,
  output logic [7:0] threshold,
  output logic       thresh_load,
  output logic [7:0] frame_mean,
  output logic       busy,
  output logic       err_drop,
  output logic       err_empty
);

  state_t state, state_nx;

  logic             vsync_d, frame_end, frame_start;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt;
  logic             sat, pix, sat_now, frame_ok;
  logic [SUM_W:0]   sum_add;
  logic             div_start, div_busy, div_done;
  logic [SUM_W-1:0] quo;
  logic [7:0]       mean, pending;
  logic [9:0]       cand;
  logic             calc_last;

  assign frame_end   = vsync_d && !vsync;
  assign frame_start = !vsync_d && vsync;
  assign pix         = vsync && de;
  assign sum_add     = {1'b0, sum} + {{(SUM_W-7){1'b0}}, luminance};
  assign sat_now     = pix && (sum_add[SUM_W] || (&cnt));
  assign frame_ok    = (cnt != '0) && !sat;

  assign mean = (|quo[SUM_W-1:8]) ? 8'hFF : quo[7:0];
  assign cand = (mean >= TH_OFFSET) ? {2'b00, mean - TH_OFFSET} : 10'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vsync_d <= 1'b0;
    else        vsync_d <= vsync;
  end

  // Accumulators always clear at frame end so the next frame is never blocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      cnt <= '0;
      sat <= 1'b0;
    end else if (frame_end) begin
      sum <= '0;
      cnt <= '0;
      sat <= 1'b0;
    end else if (pix) begin
      sum <= sum_add[SUM_W] ? '1 : sum_add[SUM_W-1:0];
      if (!(&cnt)) cnt <= cnt + 1'b1;
      if (sat_now) sat <= 1'b1;
    end
  end

  serial_udiv #(.W(SUM_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (sum),
    .divisor  ({{(SUM_W-CNT_W){1'b0}}, cnt}),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (div_start)   state_nx = DIV;
      DIV:  if (div_done)    state_nx = CALC;
      CALC: if (calc_last)   state_nx = HOLD;
      HOLD: if (frame_start) state_nx = IDLE;
      default:               state_nx = IDLE;
    endcase
  end

  always_comb begin
    div_start = (state == IDLE) && frame_end && frame_ok;
    busy      = div_busy || div_done;
  end

`ifdef BIN_TH_IIR_EN
  logic       calc_ph;
  logic [7:0] cand_r;
  logic [9:0] iir;

  assign calc_last = calc_ph;
  assign iir = (({2'b00, threshold} * 10'd3) + {2'b00, cand_r} + 10'd2) >> 2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calc_ph    <= 1'b0;
      cand_r     <= '0;
      frame_mean <= '0;
      pending    <= DEFAULT_TH;
    end else if (state == CALC) begin
      calc_ph <= !calc_ph;
      if (!calc_ph) begin
        frame_mean <= mean;
        cand_r     <= cand[7:0];
      end else begin
        pending <= clamp(iir, TH_MIN, TH_MAX);
      end
    end
  end
`else
  assign calc_last = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_mean <= '0;
      pending    <= DEFAULT_TH;
    end else if (state == CALC) begin
      frame_mean <= mean;
      pending    <= clamp(cand, TH_MIN, TH_MAX);
    end
  end
`endif

  // Threshold only moves on a frame start, so the binarizer never sees a mid-frame change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      threshold   <= DEFAULT_TH;
      thresh_load <= 1'b0;
      err_drop    <= 1'b0;
      err_empty   <= 1'b0;
    end else begin
      thresh_load <= 1'b0;
      if (frame_start) begin
        if (cfg_manual) begin
          threshold   <= cfg_thresh;
          thresh_load <= 1'b1;
        end else if (state == HOLD) begin
          threshold   <= pending;
          thresh_load <= 1'b1;
        end
      end
      if (sat_now || (frame_end && (cnt != '0) && (state != IDLE)))
        err_drop <= 1'b1;
      if (frame_end && (cnt == '0))
        err_empty <= 1'b1;
    end
  end

endmodule
